alu_seq: RTL

- Sequencing and flags stage wrapped around the two ROM-based ALU nibble slices (low and high).
- Accepts an ALU request, latches operands and control, and drives the slices through their settle window with output enable asserted.
- Captures the 8-bit result and the carry/zero/sign/overflow flags into registers, then presents the response on a valid/ready handshake.
- Sits between the instruction decode/operand path (upstream) and the slices (downstream). It consumes the slices' result and flag outputs.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_flags_reg.sv | 40 ++++
 rtl/alu_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing stage: op codes, flag bit
// positions, FSM states and the flag derivation used on capture.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_PASS = 4'h7;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_O = 3;

    localparam int unsigned CNT_W = 4;

    // Slice carry-out is active low; the stored C flag is active high.
    function automatic logic [3:0] make_flags(input logic [7:0] res,
                                              input logic       n_carry,
                                              input logic       ovf);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = ~n_carry;
        f[FLAG_Z] = (res == 8'h00);
        f[FLAG_S] = res[7];
        f[FLAG_O] = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_flags_reg.sv
// {O,S,Z,C} flag register with a direct load port and a result capture port.
module alu_flags_reg
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_en,
    input  logic [3:0] load_val,
    input  logic       cap_en,
    input  logic       cap_keep,
    input  logic [7:0] cap_result,
    input  logic       cap_n_carry,
    input  logic       cap_overflow,
    output logic [3:0] flags
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;

    // Load and capture never coincide: load is IDLE-only, capture is SETTLE-only.
    always_comb begin
        flags_d = flags_q;
        if (load_en) begin
            flags_d = load_val;
        end else if (cap_en && !cap_keep) begin
            flags_d = make_flags(cap_result, cap_n_carry, cap_overflow);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/alu_seq.sv
// Sequencer around the low/high ROM ALU slices: accepts a request, holds the
// slices enabled for SETTLE_CYCLES edges, captures result/flags, hands off.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [3:0] req_op,
    input  logic       req_invert,
    input  logic       req_carry_in,
    input  logic       req_use_carry,
    input  logic       req_keep_flags,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_result,
    output logic [3:0] flags,
    input  logic       flags_wr,
    input  logic [3:0] flags_din,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    output logic       alu_invert,
    output logic       alu_carry_in,
    output logic       alu_n_oe,
    input  logic [7:0] alu_result,
    input  logic       alu_n_carry,
    input  logic       alu_overflow
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             inv_q, inv_d;
    logic             cin_q, cin_d;
    logic             keep_q, keep_d;
    logic             n_oe_q, n_oe_d;
    logic [7:0]       result_q, result_d;

    logic             in_idle;
    logic             capture;

    assign in_idle = (state_q == ST_IDLE);
    assign capture = (state_q == ST_SETTLE) && (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        inv_d    = inv_q;
        cin_d    = cin_q;
        keep_d   = keep_q;
        n_oe_d   = n_oe_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    inv_d   = req_invert;
                    keep_d  = req_keep_flags;
                    // flags is the pre-edge value even when flags_wr loads this edge.
                    cin_d   = req_use_carry ? flags[FLAG_C] : req_carry_in;
                    cnt_d   = CNT_LOAD;
                    n_oe_d  = 1'b0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d = alu_result;
                    n_oe_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                n_oe_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            inv_q    <= 1'b0;
            cin_q    <= 1'b0;
            keep_q   <= 1'b0;
            n_oe_q   <= 1'b1;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            inv_q    <= inv_d;
            cin_q    <= cin_d;
            keep_q   <= keep_d;
            n_oe_q   <= n_oe_d;
            result_q <= result_d;
        end
    end

    alu_flags_reg u_flags (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_en      (in_idle && flags_wr),
        .load_val     (flags_din),
        .cap_en       (capture),
        .cap_keep     (keep_q),
        .cap_result   (alu_result),
        .cap_n_carry  (alu_n_carry),
        .cap_overflow (alu_overflow),
        .flags        (flags)
    );

    assign req_ready    = in_idle;
    assign resp_valid   = (state_q == ST_DONE);
    assign resp_result  = result_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign alu_invert   = inv_q;
    assign alu_carry_in = cin_q;
    assign alu_n_oe     = n_oe_q;

endmodule
